// File: rtl/eth_frame_fifo.sv
// -----------------------------------------------------------------------------
// eth_frame_fifo
//   Store-and-forward frame FIFO. The write side assembles a frame word by word.
//   A frame becomes visible to the read side only when its last word is
//   written (commit). A frame can be aborted with wr_drop. A frame is also
//   auto-dropped when it runs out of space (overflow).
//
//   Parameters
//     DATA_WIDTH  payload bits per word
//     ADDR_WIDTH  RAM address bits, DEPTH = 2**ADDR_WIDTH words
//
//   Ports
//     clk          single rising-edge clock
//     rst_n        synchronous active-low reset
//     wr_en        write word strobe
//     wr_data      write word
//     wr_last      final word of the frame (qualified by wr_en)
//     wr_drop      abort the frame being written
//     rd_en        read word request
//     rd_data      read word, registered, valid with rd_valid
//     rd_last      last-word flag of rd_data
//     rd_valid     rd_data/rd_last valid this cycle
//     frame_avail  at least one committed frame not yet fully read
//     frame_cnt    committed frames whose last word has not been read
//     wr_full      DEPTH words occupied (committed + uncommitted)
//     ovf          one-cycle pulse when a frame is dropped on overflow
// -----------------------------------------------------------------------------
module eth_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  wr_drop,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    output logic                  frame_avail,
    output logic [ADDR_WIDTH:0]   frame_cnt,
    output logic                  wr_full,
    output logic                  ovf
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // DEPTH as a pointer-width value; the top pointer bit tells full apart from empty
    localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Storage: {last, data} per word
    logic [DATA_WIDTH:0] mem [DEPTH];
    // 1-bit copy of the stored last flags. frame_cnt must be decremented in the
    // accepting cycle, before the registered RAM read returns. This copy keeps
    // the main array a pure synchronous-read RAM.
    logic                last_shadow [DEPTH];

    // State
    logic [ADDR_WIDTH:0]   wptr_q,   wptr_d;
    logic [ADDR_WIDTH:0]   wstart_q, wstart_d;
    logic [ADDR_WIDTH:0]   rptr_q,   rptr_d;
    logic [ADDR_WIDTH:0]   frame_cnt_q, frame_cnt_d;
    logic                  discard_q, discard_d;
    logic                  ovf_q,    ovf_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_last_q;

    // Per-cycle decisions
    logic                  wr_acc;
    logic                  ovf_evt;
    logic                  commit;
    logic                  rd_acc;
    logic                  rd_is_last;
    logic [ADDR_WIDTH:0]   wptr_inc;

    always_comb begin
        wr_full    = ((wptr_q - rptr_q) == DEPTH_P);
        wr_acc     = wr_en & ~wr_full & ~wr_drop & ~discard_q;
        // wr_drop already rewinds the frame, so it wins over an overflow in the same cycle
        ovf_evt    = wr_en &  wr_full & ~wr_drop & ~discard_q;
        commit     = wr_acc & wr_last;
        // Only committed words are readable: compare against wstart, not wptr
        rd_acc     = rd_en & (rptr_q != wstart_q);
        rd_is_last = rd_acc & last_shadow[rptr_q[ADDR_WIDTH-1:0]];
        wptr_inc   = wptr_q + 1'b1;
    end

    // Next-state logic
    always_comb begin
        wptr_d      = wptr_q;
        wstart_d    = wstart_q;
        rptr_d      = rptr_q;
        frame_cnt_d = frame_cnt_q;
        discard_d   = discard_q;
        ovf_d       = 1'b0;
        rd_valid_d  = rd_acc;

        // Write pointer: drop and overflow both rewind to the commit boundary
        if (wr_drop || ovf_evt) begin
            wptr_d = wstart_q;
        end else if (wr_acc) begin
            wptr_d = wptr_inc;
            if (wr_last) begin
                wstart_d = wptr_inc;
            end
        end

        // Discard lasts until the aborted frame ends (its last word) or an
        // explicit drop. An overflow that hits the last word itself ends that
        // frame at once, so discard stays clear.
        if (wr_drop) begin
            discard_d = 1'b0;
        end else if (discard_q && wr_en && wr_last) begin
            discard_d = 1'b0;
        end else if (ovf_evt) begin
            ovf_d     = 1'b1;
            discard_d = ~wr_last;
        end

        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end

        // Commit and last-word read in the same cycle cancel out
        case ({commit, rd_is_last})
            2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
            2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            wstart_q    <= '0;
            rptr_q      <= '0;
            frame_cnt_q <= '0;
            discard_q   <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            wstart_q    <= wstart_d;
            rptr_q      <= rptr_d;
            frame_cnt_q <= frame_cnt_d;
            discard_q   <= discard_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // RAM write port. Contents are not cleared by reset, but no write lands
    // while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wptr_q[ADDR_WIDTH-1:0]]         <= {wr_last, wr_data};
            last_shadow[wptr_q[ADDR_WIDTH-1:0]] <= wr_last;
        end
    end

    // RAM read port with output register. The output holds while idle.
    // A read never targets the same-cycle write address, because the word
    // being written is still uncommitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_last_q <= 1'b0;
        end else if (rd_acc) begin
            {rd_last_q, rd_data_q} <= mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_last     = rd_last_q;
    assign rd_valid    = rd_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_avail = (frame_cnt_q != '0);
    assign ovf         = ovf_q;

endmodule
